rs232_frame_controller: RTL

- Sequences the RS232 receiver's byte stream into operand frames for the root calculator.
- Detects a header byte and collects a fixed number of operand bytes, MSB first, then optionally checks an XOR checksum.
- Launches the calculator with a one-cycle start pulse and blocks new frames until the calculator reports done.
- Sits between the RS232 receiver outputs (data_ready, data, error) and the calculator's start/operand inputs.

---
 rtl/rs232_frame_controller_if.sv | 45 ++++
 rtl/rs232_frame_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rs232_frame_controller_if.sv
// Handshake bundle between the RS232 frame controller, its receiver and the root calculator.
// master: the frame controller; slave: the receiver/calculator side driving it.
interface rs232_frame_controller_if #(
  parameter int unsigned OPERAND_BYTES = 2
);
  logic                       rx_data_ready;
  logic [7:0]                 rx_data;
  logic                       rx_error;
  logic                       calc_busy;
  logic                       calc_done;
  logic                       calc_start;
  logic [OPERAND_BYTES*8-1:0] operand;
  logic                       frame_error;
  logic [1:0]                 frame_error_code;
  logic [7:0]                 drop_count;
  logic                       ctrl_busy;

  modport master (
    input  rx_data_ready,
    input  rx_data,
    input  rx_error,
    input  calc_busy,
    input  calc_done,
    output calc_start,
    output operand,
    output frame_error,
    output frame_error_code,
    output drop_count,
    output ctrl_busy
  );

  modport slave (
    output rx_data_ready,
    output rx_data,
    output rx_error,
    output calc_busy,
    output calc_done,
    input  calc_start,
    input  operand,
    input  frame_error,
    input  frame_error_code,
    input  drop_count,
    input  ctrl_busy
  );
endinterface

// File: rtl/rs232_frame_controller.sv
// Frames the RS232 byte stream into calculator operands: header, OPERAND_BYTES MSB first,
// optional XOR checksum byte (enabled by RS232_FRAME_CHECKSUM_EN), then a one-cycle launch.
module rs232_frame_controller #(
  parameter int unsigned OPERAND_BYTES  = 2,
  parameter logic [7:0]  HEADER_BYTE    = 8'h52,
  parameter int unsigned TIMEOUT_CYCLES = 156250
) (
  input logic                      clk,
  input logic                      rst_n,
  rs232_frame_controller_if.master bus_io
);

  localparam int unsigned   OpW      = OPERAND_BYTES * 8;
  localparam int unsigned   TmoW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LastByte = 3'(OPERAND_BYTES - 1);

  localparam logic [1:0] CodeTimeout  = 2'b01;
`ifdef RS232_FRAME_CHECKSUM_EN
  localparam logic [1:0] CodeChecksum = 2'b10;
`endif
  localparam logic [1:0] CodeRxError  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
`ifdef RS232_FRAME_CHECKSUM_EN
    StCheck,
`endif
    StLaunch,
    StWaitCalc
  } state_e;

  state_e          state_q;
  logic            rdy_q;
  logic [OpW-1:0]  shift_q;
  logic [2:0]      cnt_q;
  logic [TmoW-1:0] tmo_q;
`ifdef RS232_FRAME_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif
  logic [OpW-1:0]  operand_q;
  logic            calc_start_q;
  logic            frame_error_q;
  logic [1:0]      code_q;
  logic [7:0]      drop_q;
  logic            busy_q;

  logic byte_edge;
  logic accept;
  logic drop_zone;

  // A receiver error on the same edge as a new byte discards that byte.
  assign byte_edge = bus_io.rx_data_ready & ~rdy_q;
  assign accept    = byte_edge & ~bus_io.rx_error;
  assign drop_zone = (state_q == StLaunch) || (state_q == StWaitCalc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rdy_q         <= 1'b0;
      shift_q       <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
`ifdef RS232_FRAME_CHECKSUM_EN
      csum_q        <= '0;
`endif
      operand_q     <= '0;
      calc_start_q  <= 1'b0;
      frame_error_q <= 1'b0;
      code_q        <= '0;
      drop_q        <= '0;
      busy_q        <= 1'b0;
    end else begin
      rdy_q         <= bus_io.rx_data_ready;
      calc_start_q  <= 1'b0;
      frame_error_q <= 1'b0;

      if (accept && drop_zone && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end

      case (state_q)
        StIdle: begin
          if (accept && (bus_io.rx_data == HEADER_BYTE)) begin
            state_q <= StCollect;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            tmo_q   <= '0;
`ifdef RS232_FRAME_CHECKSUM_EN
            csum_q  <= HEADER_BYTE;
`endif
          end
        end

        StCollect: begin
          if (bus_io.rx_error) begin
            frame_error_q <= 1'b1;
            code_q        <= CodeRxError;
            state_q       <= StIdle;
            busy_q        <= 1'b0;
          end else if (accept) begin
            shift_q <= (shift_q << 8) | OpW'(bus_io.rx_data);
`ifdef RS232_FRAME_CHECKSUM_EN
            csum_q  <= csum_q ^ bus_io.rx_data;
`endif
            cnt_q   <= cnt_q + 3'd1;
            tmo_q   <= '0;
            if (cnt_q == LastByte) begin
`ifdef RS232_FRAME_CHECKSUM_EN
              state_q <= StCheck;
`else
              state_q <= StLaunch;
`endif
            end
          end else if (tmo_q == TmoLast) begin
            frame_error_q <= 1'b1;
            code_q        <= CodeTimeout;
            state_q       <= StIdle;
            busy_q        <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end

`ifdef RS232_FRAME_CHECKSUM_EN
        StCheck: begin
          if (bus_io.rx_error) begin
            frame_error_q <= 1'b1;
            code_q        <= CodeRxError;
            state_q       <= StIdle;
            busy_q        <= 1'b0;
          end else if (accept) begin
            tmo_q <= '0;
            if (bus_io.rx_data == csum_q) begin
              state_q <= StLaunch;
            end else begin
              frame_error_q <= 1'b1;
              code_q        <= CodeChecksum;
              state_q       <= StIdle;
              busy_q        <= 1'b0;
            end
          end else if (tmo_q == TmoLast) begin
            frame_error_q <= 1'b1;
            code_q        <= CodeTimeout;
            state_q       <= StIdle;
            busy_q        <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
`endif

        StLaunch: begin
          if (!bus_io.calc_busy) begin
            operand_q    <= shift_q;
            calc_start_q <= 1'b1;
            state_q      <= StWaitCalc;
          end
        end

        StWaitCalc: begin
          if (bus_io.calc_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.calc_start       = calc_start_q;
  assign bus_io.operand          = operand_q;
  assign bus_io.frame_error      = frame_error_q;
  assign bus_io.frame_error_code = code_q;
  assign bus_io.drop_count       = drop_q;
  assign bus_io.ctrl_busy        = busy_q;

endmodule
